// File: rtl/tetris_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tetris_display_scan
// Purpose  : Row-multiplexed LED matrix scanner. Takes a snapshot of the flat
//            game screen at the start of every frame and drives it out one row
//            at a time, holding each row for HOLD_CYCLES clocks. The snapshot
//            keeps mid-frame screen updates from tearing the visible image.
// Ports    : clock        - system clock, rising edge
//            reset        - synchronous, active-high
//            screen       - SCREEN_X*SCREEN_Y frame, bit (y*SCREEN_X + x) = cell (x,y)
//            scan_enable  - start/continue scanning (sampled in IDLE and at frame end)
//            row_data     - pixel bits of the active row, bit x = column x
//            row_select   - one-hot active-row strobe
//            row_index    - binary index of the active row
//            row_valid    - row_data/row_select meaningful
//            frame_start  - one-cycle pulse on the first cycle of row 0
//            frame_count  - completed frames, wraps 255 -> 0
// Options  : TETRIS_SCAN_BLANK_EN - insert one blank cycle after every row
//            (anti-ghosting). Undefined by default.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_display_scan #(
    parameter int SCREEN_X    = 10,
    parameter int SCREEN_Y    = 20,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [SCREEN_X*SCREEN_Y-1:0]  screen,
    input  logic                          scan_enable,
    output logic [SCREEN_X-1:0]           row_data,
    output logic [SCREEN_Y-1:0]           row_select,
    output logic [$clog2(SCREEN_Y)-1:0]   row_index,
    output logic                          row_valid,
    output logic                          frame_start,
    output logic [7:0]                    frame_count
);

    localparam int ROW_W  = $clog2(SCREEN_Y);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SCREEN_Y - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

`ifdef TETRIS_SCAN_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_BLANK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;
`endif

    state_t                         state_q,       state_d;
    logic [SCREEN_X*SCREEN_Y-1:0]   snapshot_q,    snapshot_d;
    logic [ROW_W-1:0]               row_index_q,   row_index_d;
    logic [HOLD_W-1:0]              hold_q,        hold_d;
    logic [7:0]                     frame_count_q, frame_count_d;
    logic                           row_done;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        snapshot_d    = snapshot_q;
        row_index_d   = row_index_q;
        hold_d        = hold_q;
        frame_count_d = frame_count_q;
        row_done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scan_enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                snapshot_d  = screen;
                row_index_d = '0;
                hold_d      = '0;
                state_d     = ST_SCAN;
            end
            ST_SCAN: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
`ifdef TETRIS_SCAN_BLANK_EN
                    state_d = ST_BLANK;
`else
                    row_done = 1'b1;
`endif
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
`ifdef TETRIS_SCAN_BLANK_EN
            ST_BLANK: begin
                // Row index is held through the blank; advance afterwards.
                row_done = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Row advance / frame-end decision, shared by SCAN and BLANK.
        if (row_done) begin
            if (row_index_q == ROW_LAST) begin
                frame_count_d = frame_count_q + 8'd1;
                row_index_d   = '0;
                state_d       = scan_enable ? ST_LOAD : ST_IDLE;
            end else begin
                row_index_d   = row_index_q + 1'b1;
                state_d       = ST_SCAN;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            snapshot_q    <= '0;
            row_index_q   <= '0;
            hold_q        <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            snapshot_q    <= snapshot_d;
            row_index_q   <= row_index_d;
            hold_q        <= hold_d;
            frame_count_q <= frame_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs: decoded purely from registered state
    // ------------------------------------------------------------------
    always_comb begin
        row_data    = '0;
        row_select  = '0;
        row_valid   = 1'b0;
        frame_start = 1'b0;
        if (state_q == ST_SCAN) begin
            row_valid   = 1'b1;
            row_select  = SCREEN_Y'(1) << row_index_q;
            frame_start = (row_index_q == '0) && (hold_q == '0);
            for (int y = 0; y < SCREEN_Y; y++) begin
                if (row_index_q == ROW_W'(y)) begin
                    row_data = snapshot_q[y*SCREEN_X +: SCREEN_X];
                end
            end
        end
    end

    assign row_index   = row_index_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tetris_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_display_scan
// Purpose  : Directed self-checking bench for tetris_display_scan. Drives a
//            default-size instance and a small HOLD_CYCLES=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_display_scan;

`ifdef TETRIS_SCAN_BLANK_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif
    // Default instance timing
    localparam int P     = 4 + B;             // cycles per row
    localparam int R19   = 2 + 19 * P;        // first cycle of row 19
    localparam int LOAD2 = 2 + 20 * P;        // second LOAD cycle
    localparam int F1    = 1 + 20 * P;        // frame period
    // Small instance timing (4x4, HOLD_CYCLES=1)
    localparam int P2    = 1 + B;
    localparam int F2    = 1 + 4 * P2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         scan_enable = 1'b0;
    logic [199:0] screen = '0;
    logic [15:0]  screen2 = 16'hA5C3;

    logic [9:0]   row_data;
    logic [19:0]  row_select;
    logic [4:0]   row_index;
    logic         row_valid, frame_start;
    logic [7:0]   frame_count;

    logic [3:0]   row_data2, row_select2;
    logic [1:0]   row_index2;
    logic         row_valid2, frame_start2;
    logic [7:0]   frame_count2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    tetris_display_scan dut (
        .clock(clock), .reset(reset), .screen(screen), .scan_enable(scan_enable),
        .row_data(row_data), .row_select(row_select), .row_index(row_index),
        .row_valid(row_valid), .frame_start(frame_start), .frame_count(frame_count)
    );

    tetris_display_scan #(.SCREEN_X(4), .SCREEN_Y(4), .HOLD_CYCLES(1)) dut2 (
        .clock(clock), .reset(reset), .screen(screen2), .scan_enable(scan_enable),
        .row_data(row_data2), .row_select(row_select2), .row_index(row_index2),
        .row_valid(row_valid2), .frame_start(frame_start2), .frame_count(frame_count2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Leaves the bench #1 after an edge with reset released: that is cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        scan_enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    logic [3:0] exp_rows2 [4] = '{4'h3, 4'hC, 4'h5, 4'hA};

    initial begin
        // ---------------- Run A: basic scan, snapshot, frame end, reset ----
        screen = '0;
        screen[0] = 1'b1;
        screen[199:190] = '1;
        do_reset();
        scan_enable = 1'b1;
        while (cyc <= 124) begin
            if (cyc == 0) begin
                check("rst_valid", 32'(row_valid), 32'd0);
                check("rst_sel", 32'(row_select), 32'd0);
                check("rst_data", 32'(row_data), 32'd0);
                check("rst_idx", 32'(row_index), 32'd0);
                check("rst_fs", 32'(frame_start), 32'd0);
                check("rst_fc", 32'(frame_count), 32'd0);
            end
            if (cyc == 1) check("load_valid", 32'(row_valid), 32'd0);
            if (cyc == 2) begin
                check("r0_sel", 32'(row_select), 32'd1);
                check("r0_data", 32'(row_data), 32'h001);
                check("r0_idx", 32'(row_index), 32'd0);
                check("r0_fs", 32'(frame_start), 32'd1);
                check("r0_valid", 32'(row_valid), 32'd1);
            end
            if (cyc == 3) check("r0_fs_once", 32'(frame_start), 32'd0);
            if (cyc == 5) check("r0_last_sel", 32'(row_select), 32'd1);
            if (cyc == 6) begin
                check("c6_valid", 32'(row_valid), B ? 32'd0 : 32'd1);
                check("c6_sel", 32'(row_select), B ? 32'd0 : 32'd2);
                check("c6_data", 32'(row_data), 32'd0);
            end
            if (cyc == 2 + P) begin
                check("r1_sel", 32'(row_select), 32'd2);
                check("r1_idx", 32'(row_index), 32'd1);
            end
            if (cyc == 2 + 3 * P + 1) check("r3_old_snap", 32'(row_data), 32'd0);
            if (cyc == R19 - P) check("r18_old_snap", 32'(row_data), 32'd0);
            if (cyc == R19) begin
                check("r19_data", 32'(row_data), 32'h3FF);
                check("r19_idx", 32'(row_index), 32'd19);
                check("r19_sel", 32'(row_select), 32'h80000);
            end
            if (cyc == R19 + 3) begin
                check("r19_end_data", 32'(row_data), 32'h3FF);
                check("r19_end_fc", 32'(frame_count), 32'd0);
            end
            if (cyc == LOAD2) begin
                check("f1_fc", 32'(frame_count), 32'd1);
                check("f1_load_valid", 32'(row_valid), 32'd0);
            end
            if (cyc == LOAD2 + 1) begin
                check("f2_fs", 32'(frame_start), 32'd1);
                check("f2_r0_new", 32'(row_data), 32'h3FF);
            end
            if (cyc == LOAD2 + 1 + P) check("f2_r1_new", 32'(row_data), 32'h3FF);
            if (cyc == 120) begin
                check("pre_rst_idx", 32'(row_index), 32'((120 - (LOAD2 + 1)) / P));
                check("pre_rst_valid", 32'(row_valid), 32'd1);
            end
            if (cyc == 121) begin
                check("mid_rst_valid", 32'(row_valid), 32'd0);
                check("mid_rst_sel", 32'(row_select), 32'd0);
                check("mid_rst_data", 32'(row_data), 32'd0);
                check("mid_rst_idx", 32'(row_index), 32'd0);
                check("mid_rst_fc", 32'(frame_count), 32'd0);
                reset = 1'b0;
            end
            if (cyc == 123) check("post_rst_fs", 32'(frame_start), 32'd1);
            // Small instance: one row per cycle (plus blank if enabled)
            for (int r = 0; r < 4; r++) begin
                if (cyc == 2 + r * P2) begin
                    check("s_data", 32'(row_data2), 32'(exp_rows2[r]));
                    check("s_sel", 32'(row_select2), 32'(4'b0001 << r));
                    check("s_valid", 32'(row_valid2), 32'd1);
                end
            end
            if (cyc == 1 + F2) begin
                check("s_fc", 32'(frame_count2), 32'd1);
                check("s_load_valid", 32'(row_valid2), 32'd0);
            end
            if (cyc == 10) screen = '1;
            if (cyc == 120) reset = 1'b1;
            tick();
        end

        // ---------------- Run B: scan_enable dropped mid-frame -------------
        screen = '0;
        do_reset();
        scan_enable = 1'b1;
        while (cyc <= LOAD2 + 3) begin
            if (cyc == R19 + 3) begin
                check("b_r19_valid", 32'(row_valid), 32'd1);
                check("b_r19_idx", 32'(row_index), 32'd19);
            end
            if (cyc == LOAD2) begin
                check("b_idle_valid", 32'(row_valid), 32'd0);
                check("b_idle_sel", 32'(row_select), 32'd0);
                check("b_idle_fc", 32'(frame_count), 32'd1);
            end
            if (cyc == LOAD2 + 1) check("b_idle2_valid", 32'(row_valid), 32'd0);
            if (cyc == LOAD2 + 2) check("b_load_valid", 32'(row_valid), 32'd0);
            if (cyc == LOAD2 + 3) begin
                check("b_restart_fs", 32'(frame_start), 32'd1);
                check("b_restart_data", 32'(row_data), 32'h155);
            end
            if (cyc == 20) scan_enable = 1'b0;
            if (cyc == LOAD2 + 1) begin
                scan_enable = 1'b1;
                screen = '0;
                screen[9:0] = 10'h155;
            end
            tick();
        end

        // ---------------- Run D: frame_count wrap ---------------------------
        do_reset();
        scan_enable = 1'b1;
        while (cyc <= 1 + 256 * F1) begin
            if (cyc == 1 + 255 * F2) check("s_fc_255", 32'(frame_count2), 32'd255);
            if (cyc == 1 + 256 * F2) check("s_fc_wrap", 32'(frame_count2), 32'd0);
            if (cyc == 256 * F1) check("fc_255", 32'(frame_count), 32'd255);
            if (cyc == 1 + 256 * F1) check("fc_wrap", 32'(frame_count), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
